xor_decrypt_rx: RTL

//  Receive end of the ciphertext link: deserializes the 1-bit ciphertext stream (data + flag) produced
//  by the encrypt/serialize path, XORs it with a repeating KEY_SIZE-bit key and presents the
//  MSG_SIZE-bit plaintext in parallel with a valid/ack handshake. Sits on the host/FPGA side of the link
//  or in loopback next to the encryptor for self-test.

---
 rtl/xor_decrypt_rx.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/xor_decrypt_rx.sv
// ---------------------------------------------------------------------------
// xor_decrypt_rx
// Receive end of the ciphertext link. Deserializes a 1-bit ciphertext stream
// (MSB first, framed by iData_flag), XORs the frame with a repeating
// KEY_SIZE-bit key and presents the MSG_SIZE-bit plaintext with a valid/ack
// handshake.
//
// Parameters
//   MSG_SIZE      frame length in bits (multiple of KEY_SIZE, >= 2)
//   KEY_SIZE      key length in bits; the key repeats across the frame
//
// Ports
//   clk           clock
//   rst_n         asynchronous active-low reset
//   ena           clock enable; low freezes all state
//   iData_in      serial ciphertext bit
//   iData_flag    high while frame bits are on iData_in
//   iKey          decryption key
//   iKey_load     capture iKey into the key register
//   iAck          consumer accepts oPlaintext
//   oPlaintext    decrypted frame
//   oValid        oPlaintext valid, held until iAck
//   oBusy         frame reception in progress (RECV/DECRYPT)
//   oFrame_err    1-cycle pulse on frame abort or overrun
//   oBit_counter  bits received in the current frame (saturates at MSG_SIZE)
// ---------------------------------------------------------------------------
module xor_decrypt_rx #(
  parameter int MSG_SIZE = 64,
  parameter int KEY_SIZE = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  input  logic                        iData_in,
  input  logic                        iData_flag,
  input  logic [KEY_SIZE-1:0]         iKey,
  input  logic                        iKey_load,
  input  logic                        iAck,
  output logic [MSG_SIZE-1:0]         oPlaintext,
  output logic                        oValid,
  output logic                        oBusy,
  output logic                        oFrame_err,
  output logic [$clog2(MSG_SIZE):0]   oBit_counter
);

  localparam int CNT_W = $clog2(MSG_SIZE) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(MSG_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RECV      = 2'd1,
    DECRYPT   = 2'd2,
    WAIT_FLAG = 2'd3
  } state_t;

  state_t                state_q;
  logic [KEY_SIZE-1:0]   key_q;
  logic [KEY_SIZE-1:0]   key_snap_q;
  logic [MSG_SIZE-1:0]   shift_q;
  logic [MSG_SIZE-1:0]   plaintext_q;
  logic [MSG_SIZE-1:0]   plaintext_d;
  logic                  valid_q;
  logic                  busy_q;
  logic                  err_q;
  logic [CNT_W-1:0]      cnt_q;

  // Bit i of the frame is decrypted with key bit (i mod KEY_SIZE); the key
  // snapshot is frozen for the whole frame.
  generate
    for (genvar gi = 0; gi < MSG_SIZE; gi++) begin : g_xor
      assign plaintext_d[gi] = shift_q[gi] ^ key_snap_q[gi % KEY_SIZE];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      key_q       <= '0;
      key_snap_q  <= '0;
      shift_q     <= '0;
      plaintext_q <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else if (ena) begin
      err_q <= 1'b0;

      if (iKey_load) begin
        key_q <= iKey;
      end

      // Acknowledge; a DECRYPT in the same cycle overrides this below.
      if (iAck) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          // The first flag-high cycle already carries bit 0.
          if (iData_flag) begin
            shift_q    <= {{(MSG_SIZE-1){1'b0}}, iData_in};
            key_snap_q <= key_q;
            cnt_q      <= CNT_W'(1);
            busy_q     <= 1'b1;
            state_q    <= RECV;
          end
        end

        RECV: begin
          if (iData_flag) begin
            shift_q <= {shift_q[MSG_SIZE-2:0], iData_in};
            cnt_q   <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
              state_q <= DECRYPT;
            end
          end else begin
            // Short frame: drop it, leave the last good plaintext alone.
            err_q   <= 1'b1;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end

        DECRYPT: begin
          plaintext_q <= plaintext_d;
          valid_q     <= 1'b1;
          busy_q      <= 1'b0;
          // Previous result never consumed: it is overwritten and flagged.
          if (valid_q && !iAck) begin
            err_q <= 1'b1;
          end
          // A flag-low cycle here already counts as the inter-frame gap, so
          // a frame may follow after a single low cycle.
          if (iData_flag) begin
            state_q <= WAIT_FLAG;
          end else begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end

        WAIT_FLAG: begin
          // Surplus bits beyond MSG_SIZE are ignored until the flag drops.
          if (!iData_flag) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign oPlaintext   = plaintext_q;
  assign oValid       = valid_q;
  assign oBusy        = busy_q;
  assign oFrame_err   = err_q;
  assign oBit_counter = cnt_q;

endmodule
